// File: rtl/imm_packer.sv
// Immediate packer: truncates a 32-bit operand to the selected immediate width, flags overflow,
// and queues {imm, sel, ovf, ill} in a small FIFO. Define IMM_PACKER_STATS_EN to enable ovf_count.
module imm_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_imm,
    output logic [2:0]       out_sel,
    output logic             out_ovf,
    output logic             out_ill,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef struct packed {
        logic [20:0] imm;
        logic [2:0]  sel;
        logic        ovf;
        logic        ill;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      pk;
    entry_t      last_q;
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        push, pop;

    // Unsigned range check: anything set above the field width cannot be zero-extended back.
    always_comb begin
        pk = '0;
        unique case (in_sel)
            3'd0: begin pk.imm = {5'd0, in_value[15:0]};  pk.ovf = |in_value[31:16]; end
            3'd1: begin pk.imm = in_value[20:0];          pk.ovf = |in_value[31:21]; end
            3'd2: begin pk.imm = {12'd0, in_value[8:0]};  pk.ovf = |in_value[31:9];  end
            3'd3: begin pk.imm = {3'd0, in_value[17:0]};  pk.ovf = |in_value[31:18]; end
            3'd4: begin pk.imm = {9'd0, in_value[11:0]};  pk.ovf = |in_value[31:12]; end
            default: begin pk.ovf = 1'b1; pk.ill = 1'b1; end
        endcase
        pk.sel = in_sel;
    end

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: storage is deliberately not reset; count gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pk;
    end

    // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) wr_ptr <= {1'b0, wr_ptr[AW-1:0] + 1'b1};
            if (pop) begin
                rd_ptr <= {1'b0, rd_ptr[AW-1:0] + 1'b1};
                last_q <= mem[rd_ptr[AW-1:0]];
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // When empty the outputs hold the last popped entry (zero after reset).
    assign head    = out_valid ? mem[rd_ptr[AW-1:0]] : last_q;
    assign out_imm = head.imm;
    assign out_sel = head.sel;
    assign out_ovf = head.ovf;
    assign out_ill = head.ill;

`ifdef IMM_PACKER_STATS_EN
    logic [CNT_W-1:0] ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (push && pk.ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

    assign ovf_count = ovf_cnt;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: expected entries queued on accept, compared on pop.
module tb_imm_packer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [20:0] imm;
        logic [2:0]  sel;
        logic        ovf;
        logic        ill;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic [31:0]      in_value;
    logic             out_valid;
    logic             out_ready;
    logic [20:0]      out_imm;
    logic [2:0]       out_sel;
    logic             out_ovf;
    logic             out_ill;
    logic [CNT_W-1:0] ovf_count;

    int   total = 0;
    int   bad = 0;
    int   n_pop = 0;
    int   cyc = 0;
    int   exp_ovf = 0;
    res_t sb[$];
    res_t last_pop = '0;

    imm_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_sel(out_sel), .out_ovf(out_ovf), .out_ill(out_ill),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [2:0] s, input logic [31:0] v);
        res_t r;
        int   w;
        r = '0;
        r.sel = s;
        case (s)
            3'd0: w = 16;
            3'd1: w = 21;
            3'd2: w = 9;
            3'd3: w = 18;
            3'd4: w = 12;
            default: w = 0;
        endcase
        if (w == 0) begin
            r.ovf = 1'b1;
            r.ill = 1'b1;
        end else begin
            r.imm = 21'((v << (32 - w)) >> (32 - w));
            r.ovf = (v >> w) != 0;
        end
        return r;
    endfunction

    function automatic int exp_cnt();
`ifdef IMM_PACKER_STATS_EN
        return exp_ovf;
`else
        return 0;
`endif
    endfunction

    // Monitor: sample away from the active edge; handshakes seen here complete at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 32'(out_valid), 32'd0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("out_imm", 32'(out_imm), 32'(e.imm));
                    check("out_sel", 32'(out_sel), 32'(e.sel));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    check("out_ill", 32'(out_ill), 32'(e.ill));
                    last_pop = e;
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                res_t m;
                m = model(in_sel, in_value);
                sb.push_back(m);
                if (m.ovf && exp_ovf < (1 << CNT_W) - 1) exp_ovf++;
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] v);
        int guard;
        guard = 0;
        in_sel = s;
        in_value = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        int p0, c0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sel = '0;
        in_value = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", 32'(out_imm), 32'd0);
        check("rst_out_flags", {out_sel, out_ovf, out_ill}, 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, consumer always ready.
        out_ready = 1'b1;
        send(3'd0, 32'h0000_1234);
        check("latency_valid", 32'(out_valid), 32'd1);
        send(3'd2, 32'h0000_0300);
        check("ovf_count_1", 32'(ovf_count), 32'(exp_cnt()));
        send(3'd6, 32'hFFFF_FFFF);
        send(3'd1, 32'h001F_FFFF);
        send(3'd3, 32'h0004_0000);
        send(3'd4, 32'h0000_0FFF);
        drain();
        check("hold_after_drain", 32'(out_imm), 32'(last_pop.imm));
        check("hold_valid", 32'(out_valid), 32'd0);

        // Fill with the consumer stalled, then pop once while full and offering.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(3'(i), 32'h0001_0000 * i + 32'h55 + i);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("stall_head", 32'(out_imm), 32'(sb[0].imm));
        @(negedge clk);
        check("stall_stable", 32'(out_imm), 32'(sb[0].imm));
        in_sel = 3'd0;
        in_value = 32'hAAAA;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("full_pop_ready", 32'(in_ready), 32'd1);
        check("full_no_push", sb.size(), DEPTH - 1);
        drain();

        // Streaming: one result per cycle.
        out_ready = 1'b1;
        p0 = n_pop;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i % 2 == 1) v = v >> $urandom_range(31, 8);
            send(3'($urandom_range(0, 7)), v);
        end
        check("stream_cycles", cyc - c0, 100);
        drain();
        check("stream_pops", n_pop - p0, 100);
        check("stream_ovf_count", 32'(ovf_count), 32'(exp_cnt()));

        // Asynchronous reset with entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'd2, 32'h1000 + i);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_ovf_count", 32'(ovf_count), 32'd0);
        check("arst_out_imm", 32'(out_imm), 32'd0);
        sb.delete();
        exp_ovf = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = n_pop;
        send(3'd4, 32'h0000_0ABC);
        drain();
        @(posedge clk);
        #1;
        check("post_rst_pops", n_pop - p0, 1);
        check("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef IMM_PACKER_STATS_EN
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) send(3'd2, 32'h0000_0300);
        drain();
        check("ovf_saturate", 32'(ovf_count), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imm_packer.md
# imm_packer

Immediate packer: takes a 32-bit operand value plus a size select and produces the right-justified immediate field for an instruction word. Upper bits that cannot be represented raise an overflow flag. Each result sits in a small FIFO so the instruction-assembly stage can accept it through a valid/ready handshake. The block is the inverse of the zero-extending immediate path used on decode, and it uses the same size-select encoding.

## Interface
Parameters:
- DEPTH, 4, result FIFO entries; power of two, 2..16
- CNT_W, 16, width of the overflow event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept operand this cycle
- in_sel  in  3  size select: 0=16b, 1=21b, 2=9b, 3=18b, 4=12b, 5..7 illegal
- in_value  in  32  operand to pack
- out_valid  out  1  packed result available at FIFO head
- out_ready  in  1  consumer takes result
- out_imm  out  21  packed immediate, right-justified, unused upper bits 0
- out_sel  out  3  size select carried with result
- out_ovf  out  1  value did not fit the selected width (or select illegal)
- out_ill  out  1  select was 5..7
- ovf_count  out  CNT_W  saturating count of accepted operands with out_ovf=1

## Operation
- Accept when in_valid && in_ready; in_ready = FIFO not full (registered count compare).
- Packing for width W in {16,21,9,18,12}:
  - imm = in_value[W-1:0], zero-padded to 21 bits.
  - ovf = |in_value[31:W].
  - Overflow is an unsigned range check, matching zero-extend decode.
- Illegal select: imm=0, ill=1, ovf=1.
- Each FIFO entry is {imm, sel, ovf, ill}. Write pointer, read pointer, and count are each log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Pop when out_valid && out_ready. Head fields are driven from FIFO storage.
- Full: in_ready=0. No push that cycle, even if a pop occurs in the same cycle.
- Empty: out_valid=0. out_imm/out_sel/out_ovf/out_ill hold the last popped value, or 0 after reset.
- Push and pop in the same cycle when 0 < count < DEPTH: count unchanged, both pointers advance.
- ovf_count increments once per accepted operand with ovf=1 and saturates at 2^CNT_W-1.
- The packing function is combinational on in_value/in_sel. All state is registered.

## Timing
- Reset values (asynchronous, on rst_n low):
  - Pointers, count, out_valid, out_imm, out_sel, out_ovf, out_ill, ovf_count all 0.
  - in_ready=1.
- Latency: an operand accepted at edge N appears at out_valid=1 after edge N; no fall-through in the same cycle.
- Throughput: 1 operand/cycle while the consumer keeps out_ready=1.
- in_ready depends only on registered state, never combinationally on out_ready.
- out_* stable while out_valid=1 && out_ready=0.
- Reset asserted mid-operation discards all FIFO contents immediately. No partial entry survives.

## Configuration
- IMM_PACKER_STATS_EN defined: ovf_count is implemented as specified.
- Not defined: counter logic removed, ovf_count tied to 0. The port remains so the interface is identical.

## Test plan
- Reset, then push sel=0 value=0x0000_1234 with out_ready=1 -> out_valid next cycle, out_imm=0x01234, out_ovf=0, out_ill=0.
- Push sel=2 value=0x0000_0300 -> out_imm=0x100, out_ovf=1, ovf_count=1.
- Push sel=6 value=0xFFFF_FFFF -> out_imm=0, out_ill=1, out_ovf=1.
- Hold out_ready=0, push DEPTH=4 operands -> in_ready=0 after the 4th. Assert in_valid and out_ready together while full -> one pop, no push, in_ready=1 next cycle. Results drain in FIFO order.
- Streaming 100 operands with out_ready=1 -> one result per cycle, all values and sels matching in order. With macro defined, 2^CNT_W+5 overflowing pushes -> ovf_count=0xFFFF.
- Assert rst_n=0 with 3 entries queued -> out_valid=0, ovf_count=0, in_ready=1 asynchronously. The first push after release appears as the sole entry.
